// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_array
// Purpose  : Bank of leaky integrate-and-fire membranes. MAC samples are
//            accumulated by index with saturation; a timestep pulse sweeps
//            every neuron once, one per clock, and emits one spike beat each.
// Options  : define LIF_REFRACTORY_EN to add per-neuron refractory counters.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_array #(
    parameter int N_NEURONS    = 4,
    parameter int DW           = 8,
    parameter int LEAK_SHIFT   = 1,
    parameter int THRESHOLD    = 25,
    parameter int REFRAC_STEPS = 2,
    localparam int IW          = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [IW-1:0]        in_idx,
    input  logic signed [DW-1:0] mac_out,
    output logic                 in_ready,
    input  logic                 pulse,
    output logic                 busy,
    output logic                 spk_valid,
    output logic [IW-1:0]        spk_idx,
    output logic                 spk_out,
    output logic                 err_overrun
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    localparam logic signed [DW-1:0] THR = DW'(THRESHOLD);

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [IW-1:0]        ptr;
    logic                 last;
    logic                 accept;

    logic signed [DW-1:0] v [N_NEURONS];
    logic signed [DW-1:0] acc_cur;
    logic [DW:0]          sum;
    logic signed [DW-1:0] sat_sum;
    logic signed [DW-1:0] v_sel;
    logic signed [DW-1:0] leaked;
    logic                 fire;
    logic                 refrac_sel;
    logic                 refrac_in;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pulse) state_nxt = S_SWEEP;
            S_SWEEP: if (last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_SWEEP);
        in_ready = (state == S_IDLE) && !reset;
    end

    assign last   = (ptr == IW'(N_NEURONS - 1));
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset)              ptr <= '0;
        else if (busy && !last) ptr <= ptr + IW'(1);
        else                    ptr <= '0;
    end

    // Sign-extended add; overflow shows as disagreement of the top two bits.
    assign acc_cur = v[in_idx];
    assign sum     = {acc_cur[DW-1], acc_cur} + {mac_out[DW-1], mac_out};
    assign sat_sum = (sum[DW] != sum[DW-1]) ? {sum[DW], {(DW-1){~sum[DW]}}}
                                            : sum[DW-1:0];

    assign v_sel  = v[ptr];
    assign leaked = v_sel >>> LEAK_SHIFT;
    assign fire   = !refrac_sel && (leaked >= THR);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (reset) begin
                v[i] <= '0;
            end else if (busy && ptr == IW'(i)) begin
                v[i] <= fire ? leaked - THR : leaked;
            end else if (accept && in_idx == IW'(i) && !refrac_in) begin
                v[i] <= sat_sum;
            end
        end
    end

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);

    logic [RW-1:0] rc [N_NEURONS];

    assign refrac_sel = (rc[ptr] != '0);
    assign refrac_in  = (rc[in_idx] != '0);

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (reset) begin
                rc[i] <= '0;
            end else if (busy && ptr == IW'(i)) begin
                if (fire)               rc[i] <= RW'(REFRAC_STEPS);
                else if (rc[i] != '0)   rc[i] <= rc[i] - RW'(1);
            end
        end
    end
`else
    assign refrac_sel = 1'b0;
    assign refrac_in  = 1'b0;
`endif

    // Beat outputs hold their last index/value between sweeps.
    always_ff @(posedge clk) begin
        if (reset) begin
            spk_valid   <= 1'b0;
            spk_idx     <= '0;
            spk_out     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            spk_valid <= busy;
            if (busy) begin
                spk_idx <= ptr;
                spk_out <= fire;
            end
            if (busy && pulse) err_overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_array
// Purpose  : Scoreboard bench for lif_neuron_array with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 8;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b1;
    logic                 in_valid = 1'b0;
    logic [IW-1:0]        in_idx   = '0;
    logic signed [DW-1:0] mac_out  = '0;
    logic                 pulse    = 1'b0;
    logic                 in_ready;
    logic                 busy;
    logic                 spk_valid;
    logic [IW-1:0]        spk_idx;
    logic                 spk_out;
    logic                 err_overrun;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_idx_q [$];
    logic          exp_out_q [$];

    always #5 clk = ~clk;

    lif_neuron_array #(
        .N_NEURONS    (N),
        .DW           (DW),
        .LEAK_SHIFT   (1),
        .THRESHOLD    (25),
        .REFRAC_STEPS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_idx      (in_idx),
        .mac_out     (mac_out),
        .in_ready    (in_ready),
        .pulse       (pulse),
        .busy        (busy),
        .spk_valid   (spk_valid),
        .spk_idx     (spk_idx),
        .spk_out     (spk_out),
        .err_overrun (err_overrun)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (spk_valid) begin
            if (exp_idx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got idx %0d out %0d, expected no beat",
                         spk_idx, spk_out);
            end else begin
                check("beat_idx", int'(spk_idx), int'(exp_idx_q.pop_front()));
                check("beat_out", int'(spk_out), int'(exp_out_q.pop_front()));
            end
        end
    end

    task automatic push_sweep(input logic [N-1:0] pat);
        for (int i = 0; i < N; i++) begin
            exp_idx_q.push_back(IW'(i));
            exp_out_q.push_back(pat[i]);
        end
    endtask

    task automatic acc(input logic [IW-1:0] idx, input logic signed [DW-1:0] val);
        in_valid = 1'b1;
        in_idx   = idx;
        mac_out  = val;
        tick();
        in_valid = 1'b0;
    endtask

    // One timestep: pattern bit i = expected spk_out for neuron i.
    task automatic do_step(input logic [N-1:0] pat, input bit dbl, input bit with_in,
                           input logic [IW-1:0] idx, input logic signed [DW-1:0] val,
                           input string tag);
        int n;
        push_sweep(pat);
        pulse = 1'b1;
        if (with_in) begin
            in_valid = 1'b1;
            in_idx   = idx;
            mac_out  = val;
        end
        tick();
        pulse    = 1'b0;
        in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            pulse = dbl && (k == 1);
            if (!busy) break;
            if (k == 0) check({tag, "_in_ready_busy"}, int'(in_ready), 0);
            n++;
            tick();
        end
        pulse = 1'b0;
        check({tag, "_busy_cycles"}, n, N);
        check({tag, "_in_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_spk_valid", int'(spk_valid), 0);
        check("rst_spk_out", int'(spk_out), 0);
        check("rst_spk_idx", int'(spk_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_overrun", int'(err_overrun), 0);
        check("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        tick();
        check("rel_in_ready", int'(in_ready), 1);
        check("rel_busy", int'(busy), 0);

        // v0 = 60 -> leak 30 fires, leaves 5
        acc(2'd0, 8'sd60);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "t2");

        // v1 saturates at 127 -> leak 63 fires, leaves 38
        acc(2'd1, 8'sd100);
        acc(2'd1, 8'sd100);
        do_step(4'b0010, 1'b0, 1'b0, '0, '0, "t3");

        // v2 = -7 -> -4 -> -2, never fires
        acc(2'd2, -8'sd7);
        do_step(4'b0000, 1'b0, 1'b0, '0, '0, "t4a");
        do_step(4'b0000, 1'b0, 1'b0, '0, '0, "t4b");
        check("ovr_clear", int'(err_overrun), 0);

        // second pulse during sweep is ignored and flags overrun
        do_step(4'b0000, 1'b1, 1'b0, '0, '0, "t5a");
        check("ovr_set", int'(err_overrun), 1);

        // input and pulse in the same cycle: sweep sees v3 = 60
        do_step(4'b1000, 1'b0, 1'b1, 2'd3, 8'sd60, "t5b");
        check("ovr_sticky", int'(err_overrun), 1);

        // v2 = -1-100-100 clamps at -128 (a wrap would give +55 and fire);
        // v0 = 49 leaks to 24, one below threshold
        acc(2'd2, -8'sd100);
        acc(2'd2, -8'sd100);
        acc(2'd0, 8'sd49);
        do_step(4'b0000, 1'b0, 1'b0, '0, '0, "sat_neg");

        // v0 = 24 + 26 = 50 leaks to exactly 25 and fires
        acc(2'd0, 8'sd26);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "thr_edge");

        // reset after two beats aborts the sweep
        push_sweep(4'b0000);
        void'(exp_idx_q.pop_back());
        void'(exp_out_q.pop_back());
        void'(exp_idx_q.pop_back());
        void'(exp_out_q.pop_back());
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_spk_valid", int'(spk_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_err_overrun", int'(err_overrun), 0);
        check("abort_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        tick();
        tick();
        check("abort_busy_after", int'(busy), 0);
        check("abort_in_ready_after", int'(in_ready), 1);

`ifdef LIF_REFRACTORY_EN
        // fire, two refractory steps with dropped input, then fire again
        acc(2'd0, 8'sd60);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "r1");
        acc(2'd0, 8'sd60);
        do_step(4'b0000, 1'b0, 1'b0, '0, '0, "r2");
        acc(2'd0, 8'sd60);
        do_step(4'b0000, 1'b0, 1'b0, '0, '0, "r3");
        acc(2'd0, 8'sd60);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "r4");
`else
        // without refractory a neuron may fire on consecutive steps: 5+60 -> 32
        acc(2'd0, 8'sd60);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "c1");
        acc(2'd0, 8'sd60);
        do_step(4'b0001, 1'b0, 1'b0, '0, '0, "c2");
`endif

        tick();
        tick();
        check("queue_empty", exp_idx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
